// File: rtl/stack_arbiter_ctrl.sv
// stack_arbiter_ctrl: shares one single-port stack RAM between two requesters, owns Count/Full/Empty.
// Latency: Ack 2 cycles after Req is sampled in IDLE for push or rejected op, 3 cycles for a successful pop.
// Backpressure: one operation in flight; the losing requester holds Req in IDLE. STACK_ARB_FIXED_PRIORITY_EN selects fixed priority.
module stack_arbiter_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              Op0,
    input  logic [DATA_W-1:0] Din0,
    output logic              Ack0,
    input  logic              Req1,
    input  logic              Op1,
    input  logic [DATA_W-1:0] Din1,
    output logic              Ack1,
    output logic              Err,
    output logic [DATA_W-1:0] Dout,
    output logic              RamEn,
    output logic              RamWe,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [DATA_W-1:0] RamWdata,
    input  logic [DATA_W-1:0] RamRdata,
    output logic [ADDR_W:0]   Count,
    output logic              Full,
    output logic              Empty
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, OP, RD_WAIT, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W:0]     count_dec;
    logic                gnt_q;      // 0 = port 0 owns the current operation
    logic                op_q;       // 1 = push
    logic [DATA_W-1:0]   din_q;
    logic                err_q;
    logic [DATA_W-1:0]   dout_q;
    logic                grant_any;
    logic                gnt_sel;
    logic                do_push;
    logic                do_pop;
    logic                reject;
`ifndef STACK_ARB_FIXED_PRIORITY_EN
    logic                rr_q;       // port preferred on the next simultaneous request
`endif

    assign Count     = count_q;
    assign Full      = (count_q == DEPTH);
    assign Empty     = (count_q == '0);
    assign Dout      = dout_q;
    assign count_dec = count_q - ONE;

    // Arbitration: pick which port wins in IDLE
    always_comb begin
        grant_any = Req0 | Req1;
`ifdef STACK_ARB_FIXED_PRIORITY_EN
        gnt_sel   = ~Req0;
`else
        if (Req0 && Req1) begin
            gnt_sel = rr_q;
        end else begin
            gnt_sel = ~Req0;
        end
`endif
    end

    // Classify the operation being executed in OP; full/empty turn it into a rejection
    always_comb begin
        do_push = (state == OP) && op_q && !Full;
        do_pop  = (state == OP) && !op_q && !Empty;
        reject  = (state == OP) && !do_push && !do_pop;
    end

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = OP;
            OP:      state_nxt = do_pop ? RD_WAIT : DONE;
            RD_WAIT: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: RAM strobes only in OP, acknowledge and error only in DONE
    always_comb begin
        Ack0     = (state == DONE) && !gnt_q;
        Ack1     = (state == DONE) && gnt_q;
        Err      = (state == DONE) && err_q;
        RamEn    = do_push | do_pop;
        RamWe    = do_push;
        RamAddr  = '0;
        RamWdata = '0;
        if (do_push) begin
            RamAddr  = count_q[ADDR_W-1:0];
            RamWdata = din_q;
        end else if (do_pop) begin
            RamAddr  = count_dec[ADDR_W-1:0];
        end
    end

    // Datapath: latch the granted request, move the stack pointer, capture pop data
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
            gnt_q   <= 1'b0;
            op_q    <= 1'b0;
            din_q   <= '0;
            err_q   <= 1'b0;
            dout_q  <= '0;
`ifndef STACK_ARB_FIXED_PRIORITY_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        gnt_q <= gnt_sel;
                        op_q  <= gnt_sel ? Op1 : Op0;
                        din_q <= gnt_sel ? Din1 : Din0;
`ifndef STACK_ARB_FIXED_PRIORITY_EN
                        if (Req0 && Req1) begin
                            rr_q <= ~gnt_sel;
                        end
`endif
                    end
                end
                OP: begin
                    err_q <= reject;
                    if (do_push) begin
                        count_q <= count_q + ONE;
                    end else if (do_pop) begin
                        count_q <= count_dec;
                    end
                end
                RD_WAIT: begin
                    dout_q <= RamRdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_arbiter_ctrl.sv
// Bench for stack_arbiter_ctrl with a 4-entry stack and a behavioural RAM.
// A transaction-level model predicts every output each cycle; directed scenarios add literal checks.
// Requesters hold Req until Ack and drop it right after the Ack cycle.
module tb_stack_arbiter_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          Clk   = 1'b0;
    logic          Reset = 1'b1;
    logic          Req0  = 1'b0;
    logic          Op0   = 1'b0;
    logic [DW-1:0] Din0  = '0;
    logic          Req1  = 1'b0;
    logic          Op1   = 1'b0;
    logic [DW-1:0] Din1  = '0;
    logic          Ack0, Ack1, Err, RamEn, RamWe, Full, Empty;
    logic [DW-1:0] Dout, RamWdata;
    logic [DW-1:0] RamRdata = '0;
    logic [AW-1:0] RamAddr;
    logic [AW:0]   Count;

    int checks = 0;
    int fails  = 0;

    stack_arbiter_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .Op0(Op0), .Din0(Din0), .Ack0(Ack0),
        .Req1(Req1), .Op1(Op1), .Din1(Din1), .Ack1(Ack1),
        .Err(Err), .Dout(Dout),
        .RamEn(RamEn), .RamWe(RamWe), .RamAddr(RamAddr), .RamWdata(RamWdata), .RamRdata(RamRdata),
        .Count(Count), .Full(Full), .Empty(Empty)
    );

    always #5 Clk = ~Clk;

    // Single-port RAM, read data one cycle after the read strobe
    logic [DW-1:0] mem [DEPTH];
    always @(posedge Clk) begin
        if (RamEn) begin
            if (RamWe) mem[RamAddr] <= RamWdata;
            else       RamRdata     <= mem[RamAddr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model
    int            m_count = 0;
    int            m_phase = 0;   // 0 idle, 1 OP, then cycles until m_lat (ack cycle)
    int            m_lat   = 2;
    bit            m_rr    = 1'b0;
    bit            m_port, m_push, m_err;
    logic [DW-1:0] m_din, m_pop;
    logic [DW-1:0] m_dout  = '0;
    logic [DW-1:0] m_stack [DEPTH];

    always @(negedge Clk) begin
        int  cur;
        int  e_addr;
        bit  e_ack0, e_ack1, e_err, e_en, e_we, p;
        if (Reset) begin
            m_count = 0; m_phase = 0; m_rr = 1'b0; m_dout = '0;
            chk("rst_ack0",  32'(Ack0), 0);
            chk("rst_ack1",  32'(Ack1), 0);
            chk("rst_err",   32'(Err), 0);
            chk("rst_ramen", 32'(RamEn), 0);
            chk("rst_ramwe", 32'(RamWe), 0);
            chk("rst_addr",  32'(RamAddr), 0);
            chk("rst_dout",  32'(Dout), 0);
            chk("rst_count", 32'(Count), 0);
            chk("rst_empty", 32'(Empty), 1);
            chk("rst_full",  32'(Full), 0);
        end else begin
            cur    = m_phase;
            e_en   = (cur == 1) && !m_err;
            e_we   = e_en && m_push;
            e_addr = m_push ? m_count : m_count - 1;
            e_ack0 = (cur != 0) && (cur == m_lat) && !m_port;
            e_ack1 = (cur != 0) && (cur == m_lat) && m_port;
            e_err  = (cur != 0) && (cur == m_lat) && m_err;
            chk("ack0",  32'(Ack0), 32'(e_ack0));
            chk("ack1",  32'(Ack1), 32'(e_ack1));
            chk("err",   32'(Err), 32'(e_err));
            chk("ramen", 32'(RamEn), 32'(e_en));
            chk("ramwe", 32'(RamWe), 32'(e_we));
            if (e_en) chk("ramaddr", 32'(RamAddr), 32'(e_addr));
            if (e_we) chk("ramwdata", 32'(RamWdata), 32'(m_din));
            chk("count", 32'(Count), 32'(m_count));
            chk("full",  32'(Full), 32'(m_count == DEPTH));
            chk("empty", 32'(Empty), 32'(m_count == 0));
            chk("dout",  32'(Dout), 32'(m_dout));
            // Advance the model by one cycle
            if (cur == 1 && !m_err) begin
                if (m_push) begin
                    m_stack[m_count] = m_din;
                    m_count++;
                end else begin
                    m_pop = m_stack[m_count-1];
                    m_count--;
                end
            end
            if (cur == 2 && !m_push && !m_err) m_dout = m_pop;
            if (cur == 0) begin
                if (Req0 || Req1) begin
`ifdef STACK_ARB_FIXED_PRIORITY_EN
                    p = !Req0;
`else
                    if (Req0 && Req1) begin
                        p    = m_rr;
                        m_rr = !p;
                    end else begin
                        p = !Req0;
                    end
`endif
                    m_port  = p;
                    m_push  = p ? Op1 : Op0;
                    m_din   = p ? Din1 : Din0;
                    m_err   = m_push ? (m_count == DEPTH) : (m_count == 0);
                    m_lat   = (!m_push && !m_err) ? 3 : 2;
                    m_phase = 1;
                end
            end else if (cur == m_lat) begin
                m_phase = 0;
            end else begin
                m_phase = cur + 1;
            end
        end
    end

    // Record the order in which ports are acknowledged
    int ack_q[$];
    always @(negedge Clk) begin
        if (!Reset) begin
            if (Ack0) ack_q.push_back(0);
            if (Ack1) ack_q.push_back(1);
        end
    end

    task automatic do_op(input int port, input logic op, input logic [DW-1:0] d,
                         output logic err, output logic [DW-1:0] dout);
        int n;
        bit got;
        n = 0; got = 1'b0; err = 1'b0; dout = '0;
        if (port == 0) begin Req0 = 1'b1; Op0 = op; Din0 = d; end
        else           begin Req1 = 1'b1; Op1 = op; Din1 = d; end
        while (!got && n < 20) begin
            @(negedge Clk);
            n++;
            if ((port == 0) ? Ack0 : Ack1) begin
                got = 1'b1; err = Err; dout = Dout;
            end
        end
        if (!got) begin
            checks++; fails++;
            $display("FAIL ack_timeout port %0d: got no ack, expected ack within 20 cycles", port);
        end
        @(posedge Clk); #1;
        if (port == 0) Req0 = 1'b0; else Req1 = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge Clk); #1 Reset = 1'b1;
        repeat (2) @(negedge Clk);
        @(posedge Clk); #1 Reset = 1'b0;
    endtask

    initial begin
        logic          e;
        logic [DW-1:0] d;
        int            n;

        repeat (3) @(negedge Clk);
        chk("lit_rst_count", 32'(Count), 0);
        chk("lit_rst_empty", 32'(Empty), 1);
        chk("lit_rst_dout",  32'(Dout), 0);
        @(posedge Clk); #1 Reset = 1'b0;

        // Single push
        do_op(0, 1'b1, 8'hA5, e, d);
        chk("lit_push_a5_err",   32'(e), 0);
        chk("lit_push_a5_count", 32'(Count), 1);
        chk("lit_push_a5_empty", 32'(Empty), 0);

        // Push two more from port 0, pop from port 1
        do_op(0, 1'b1, 8'h11, e, d);
        do_op(0, 1'b1, 8'h22, e, d);
        do_op(1, 1'b0, 8'h00, e, d);
        chk("lit_pop_22_dout",  32'(d), 32'h22);
        chk("lit_pop_22_err",   32'(e), 0);
        chk("lit_pop_22_count", 32'(Count), 2);

        // Both ports pushing with requests held continuously
        do_reset();
        ack_q.delete();
        fork
            begin
                logic ea; logic [DW-1:0] da;
                for (int i = 0; i < 2; i++) do_op(0, 1'b1, 8'(16 + i), ea, da);
            end
            begin
                logic eb; logic [DW-1:0] db;
                for (int i = 0; i < 2; i++) do_op(1, 1'b1, 8'(32 + i), eb, db);
            end
        join
        chk("lit_arb_acks", 32'(ack_q.size()), 4);
        if (ack_q.size() == 4) begin
`ifdef STACK_ARB_FIXED_PRIORITY_EN
            chk("lit_arb_order", 32'({ack_q[0][0], ack_q[1][0], ack_q[2][0], ack_q[3][0]}), 32'b0011);
`else
            chk("lit_arb_order", 32'({ack_q[0][0], ack_q[1][0], ack_q[2][0], ack_q[3][0]}), 32'b0101);
`endif
        end
        chk("lit_full_count", 32'(Count), 4);
        chk("lit_full_flag",  32'(Full), 1);

        // Push into a full stack is rejected
        do_op(0, 1'b1, 8'h99, e, d);
        chk("lit_full_push_err",   32'(e), 1);
        chk("lit_full_push_count", 32'(Count), 4);

        // Pop returns the last pushed value
        do_op(1, 1'b0, 8'h00, e, d);
        chk("lit_pop_top_dout",  32'(d), 32'h21);
        chk("lit_pop_top_full",  32'(Full), 0);
        chk("lit_pop_top_count", 32'(Count), 3);

        // Drain, then pop from empty
        for (int i = 0; i < 3; i++) do_op(0, 1'b0, 8'h00, e, d);
        do_op(0, 1'b0, 8'h00, e, d);
        chk("lit_empty_pop_err",   32'(e), 1);
        chk("lit_empty_pop_dout",  32'(d), 32'h10);
        chk("lit_empty_pop_count", 32'(Count), 0);
        chk("lit_empty_pop_empty", 32'(Empty), 1);

        // Reset during RD_WAIT of a pop
        do_op(0, 1'b1, 8'h77, e, d);
        Req1 = 1'b1; Op1 = 1'b0; Din1 = '0;
        n = 0;
        while (!(RamEn && !RamWe) && n < 10) begin
            @(negedge Clk);
            n++;
        end
        chk("lit_reach_pop_op", 32'(RamEn && !RamWe), 1);
        @(posedge Clk); #2;
        Reset = 1'b1;
        Req1  = 1'b0;
        #1;
        chk("lit_abort_count", 32'(Count), 0);
        chk("lit_abort_empty", 32'(Empty), 1);
        @(negedge Clk);
        chk("lit_abort_ack1", 32'(Ack1), 0);
        @(posedge Clk); #1 Reset = 1'b0;
        repeat (3) @(negedge Clk);

        // Normal operation after the abort
        do_op(0, 1'b1, 8'h3C, e, d);
        do_op(1, 1'b0, 8'h00, e, d);
        chk("lit_post_rst_dout",  32'(d), 32'h3C);
        chk("lit_post_rst_count", 32'(Count), 0);

        repeat (2) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/stack_arbiter_ctrl.md
Name: stack_arbiter_ctrl

Overview:
- Controller and arbiter that shares one single-port stack RAM between two requesters (port 0, port 1).
- Owns the top-of-stack pointer and the Full/Empty/Count status.
- Serialises push/pop requests and sequences the RAM address/enable/write strobes.
- Returns pop data and a one-cycle acknowledge to the granted requester.

Parameters:
- DATA_W, 8, data width of stack entries and requester data buses
- ADDR_W, 10, RAM address width; stack depth is 2**ADDR_W entries

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- Req0  input  1  port 0 request, held until Ack0
- Op0  input  1  port 0 operation: 1 = push, 0 = pop
- Din0  input  DATA_W  port 0 push data, held with Req0
- Ack0  output  1  port 0 one-cycle completion pulse
- Req1  input  1  port 1 request
- Op1  input  1  port 1 operation, same encoding as Op0
- Din1  input  DATA_W  port 1 push data
- Ack1  output  1  port 1 one-cycle completion pulse
- Err  output  1  high with Ack when the operation was rejected (push when full, pop when empty)
- Dout  output  DATA_W  pop data, registered, valid with Ack of a successful pop
- RamEn  output  1  RAM access enable
- RamWe  output  1  RAM write strobe (1 = write)
- RamAddr  output  ADDR_W  RAM address
- RamWdata  output  DATA_W  RAM write data
- RamRdata  input  DATA_W  RAM read data, valid one cycle after RamEn with RamWe = 0
- Count  output  ADDR_W+1  number of entries on the stack
- Full  output  1  Count == 2**ADDR_W
- Empty  output  1  Count == 0

Behaviour:
- Reset, asynchronous and immediate:
  - state = IDLE; Count = 0; Empty = 1; Full = 0.
  - Ack0, Ack1, Err, RamEn and RamWe = 0; Dout = 0; RamAddr = 0.
  - Round-robin pointer = port 0 preferred.
- Reset asserted mid-operation aborts the operation: no Ack, Count is not changed by the aborted operation.
- FSM states: IDLE, OP, RD_WAIT, DONE.
- IDLE:
  - If exactly one Req is high, grant that port.
  - If both are high, grant the port the RR pointer prefers, then point the RR pointer at the other port.
  - Latch the granted port's Op and Din.
  - Go to OP. With no request, stay in IDLE.
- OP, push, not full: RamEn = 1, RamWe = 1, RamAddr = Count[ADDR_W-1:0], RamWdata = latched Din; Count increments at the end of the cycle; go to DONE.
- OP, pop, not empty: RamEn = 1, RamWe = 0, RamAddr = Count-1; Count decrements at the end of the cycle; go to RD_WAIT.
- OP, push when Full or pop when Empty: no RAM access, Count unchanged, Err is set for DONE; go to DONE.
- RD_WAIT: capture RamRdata into Dout; go to DONE.
- DONE:
  - Pulse the granted port's Ack for exactly one cycle. Err is valid in the same cycle.
  - Dout holds its value until the next successful pop.
  - Return to IDLE.
- Latency from Req sampled in IDLE:
  - Push: Ack 2 cycles later.
  - Pop: Ack 3 cycles later.
  - Rejected operation: Ack 2 cycles later.
- Requester rules:
  - Hold Req, Op and Din stable until Ack.
  - A Req still high in the cycle after Ack is a new request.
  - The other port's Req waits in IDLE; nothing is lost.
- Full, Empty and Count are combinational from the Count register; they update the cycle after OP.
- No wrap-around: Count saturates logically by rejection and never exceeds 2**ADDR_W or drops below 0.
- Only one RAM access is in flight at a time; RamEn and RamWe are 0 outside OP.

Optional Feature:
- Macro: STACK_ARB_FIXED_PRIORITY_EN
- Defined: port 0 always wins simultaneous requests and the RR pointer is removed. Port 1 is granted only when Req0 is low in IDLE.
- Undefined: round-robin arbitration as described in Behaviour.

Test Plan:
- Reset, then port 0 pushes 0xA5 → RamWe = 1 at addr 0 two cycles later, Ack0 pulse, Count = 1, Empty = 0, Err = 0.
- Port 0 pushes 0x11 then 0x22, port 1 pops → Ack1 with Dout = 0x22, RamAddr = 1 during OP, Count = 1.
- Req0 and Req1 both held high continuously, each pushing → grants alternate 0, 1, 0, 1, Count increments by 1 per Ack. With STACK_ARB_FIXED_PRIORITY_EN, only port 0 is acked.
- Pop from empty stack → Ack with Err = 1, RamEn never asserted, Count = 0, Dout unchanged.
- ADDR_W = 2: push 4 values → Full = 1, Count = 4; 5th push → Err = 1, no RamWe; pop returns the 4th value, Full = 0.
- Assert Reset during RD_WAIT of a pop → no Ack, Count = 0, Empty = 1, state IDLE immediately.
